// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: the producer/consumer side drives
// the master modport, the FIFO implements the slave modport.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  WR_EN;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  RD_EN;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_VALID;
  logic                  EMPTY;
  logic                  FULL;
  logic                  ALMOST_EMPTY;
  logic                  ALMOST_FULL;
  logic                  PROG_EMPTY;
  logic                  PROG_FULL;
  logic [DEPTH_LOG2:0]   DATA_COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output WR_EN, WR_DATA, RD_EN,
    input  RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
           PROG_EMPTY, PROG_FULL, DATA_COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_EN,
    output RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
           PROG_EMPTY, PROG_FULL, DATA_COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// occupancy count, registered status flags and overflow/underflow pulses.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH        = 36,
  parameter int unsigned DEPTH_LOG2        = 10,
  parameter string       FWFT              = "FALSE",
  parameter int unsigned PROG_EMPTY_THRESH = 4,
  parameter int unsigned PROG_FULL_THRESH  = (2 ** DEPTH_LOG2) - 4
) (
  input logic              CLK,
  input logic              RESET_N,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam bit          IsFwft = (FWFT == "TRUE");

  localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);
  localparam logic [CntW-1:0]       CntOne   = CntW'(1);
  localparam logic [CntW-1:0]       CntZero  = '0;
  localparam logic [CntW-1:0]       CntFull  = CntW'(Depth);
  localparam logic [CntW-1:0]       CntAFull = CntW'(Depth - 1);
  localparam logic [CntW-1:0]       PeThresh = CntW'(PROG_EMPTY_THRESH);
  localparam logic [CntW-1:0]       PfThresh = CntW'(PROG_FULL_THRESH);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 72 || DEPTH_LOG2 < 2 || DEPTH_LOG2 > 15 ||
      (FWFT != "TRUE" && FWFT != "FALSE") ||
      PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > Depth - 1 ||
      PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > Depth - 1) begin : gen_bad_params
    $error("Error: illegal parameter value in %m");
  end

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  wr_acc, rd_acc;
  logic                  empty_q, full_q, almost_empty_q, almost_full_q;
  logic                  prog_empty_q, prog_full_q, overflow_q, underflow_q;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, head;

  assign head   = mem[rd_ptr_q];
  assign wr_acc = bus.WR_EN & ~full_q;
  assign rd_acc = bus.RD_EN & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CntOne;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CntOne;
    end
  end

  // FWFT keeps tracking the head so RD_DATA holds the last shown word once empty.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (IsFwft) begin
      if (!empty_q) rd_data_d = head;
    end else begin
      rd_valid_d = rd_acc;
      if (rd_acc) rd_data_d = head;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.WR_DATA;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b0;
      almost_full_q  <= 1'b0;
      prog_empty_q   <= 1'b1;
      prog_full_q    <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q        <= count_d;
      empty_q        <= (count_d == CntZero);
      full_q         <= (count_d == CntFull);
      almost_empty_q <= (count_d == CntOne);
      almost_full_q  <= (count_d == CntAFull);
      prog_empty_q   <= (count_d <= PeThresh);
      prog_full_q    <= (count_d >= PfThresh);
      overflow_q     <= bus.WR_EN & full_q;
      underflow_q    <= bus.RD_EN & empty_q;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign bus.RD_DATA      = (IsFwft && !empty_q) ? head : rd_data_q;
  assign bus.RD_VALID     = IsFwft ? ~empty_q : rd_valid_q;
  assign bus.EMPTY        = empty_q;
  assign bus.FULL         = full_q;
  assign bus.ALMOST_EMPTY = almost_empty_q;
  assign bus.ALMOST_FULL  = almost_full_q;
  assign bus.PROG_EMPTY   = prog_empty_q;
  assign bus.PROG_FULL    = prog_full_q;
  assign bus.DATA_COUNT   = count_q;
  assign bus.OVERFLOW     = overflow_q;
  assign bus.UNDERFLOW    = underflow_q;
endmodule
